// File: rtl/core101_pkg.sv
// Shared definitions for the Core101 instruction-fetch front end.
// Holds the default address width, the NOP encoding returned by an empty
// prefetch queue, the sequential PC increment and the fetch FSM state type.
package core101_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam int unsigned PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/core101_sync_fifo.sv
// Synchronous FIFO with flush, used as the prefetch queue.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   push, push_data  write an entry (ignored when full)
//   pop              remove the head entry (ignored when empty)
//   flush            discard all entries; overrides push and pop
//   head_data        current head entry (undefined when empty)
//   count            occupancy, 0..DEPTH
//   empty, full      occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module core101_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: PC sequencer, single-outstanding memory
// request/valid handshake, DEPTH-entry {pc, instruction} prefetch queue,
// halt and redirect (flush) support.
// Ports:
//   clock_in, reset_in           clock, synchronous active-high reset
//   halt_in                      block new memory requests
//   redirect_in/redirect_addr_in flush queue, restart at word-aligned target
//   mem_addr_out, mem_read_out   memory request (held until mem_valid_in)
//   mem_valid_in, mem_data_in    memory response
//   ins_valid_out, ins_data_out,
//   ins_pc_out, ins_ready_in     queue head towards decode
//   queue_count_out              queue occupancy
module ifu_prefetch
  import core101_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     halt_in,
  input  logic                     redirect_in,
  input  logic [XLEN-1:0]          redirect_addr_in,
  output logic [XLEN-1:0]          mem_addr_out,
  output logic                     mem_read_out,
  input  logic                     mem_valid_in,
  input  logic [31:0]              mem_data_in,
  output logic                     ins_valid_out,
  output logic [31:0]              ins_data_out,
  output logic [XLEN-1:0]          ins_pc_out,
  input  logic                     ins_ready_in,
  output logic [$clog2(DEPTH):0]   queue_count_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned W  = XLEN + 32;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] drop_addr;
  logic            push, pop;
  logic [CW-1:0]   count, count_after;
  logic            room;
  logic            empty, full;
  logic [W-1:0]    head;

  // The two low bits of the redirect target are forced to zero.
  logic unused_addr_bits;
  assign unused_addr_bits = ^redirect_addr_in[1:0];

  core101_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clock_in),
    .rst       (reset_in),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_in),
    .push_data ({fetch_pc, mem_data_in}),
    .head_data (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    push          = (state == REQ) && mem_valid_in && !redirect_in;
    pop           = ins_ready_in && !empty && !redirect_in;
    // Occupancy after this cycle's push/pop decides whether to issue.
    count_after   = count + CW'(push) - CW'(pop);
    room          = count_after < CW'(DEPTH);
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (redirect_in) begin
      fetch_pc_next = {redirect_addr_in[XLEN-1:2], 2'b00};
      // An outstanding request must still complete its handshake.
      if (state != IDLE && !mem_valid_in) state_next = DROP;
      else                                state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (!halt_in && room) state_next = REQ;
        REQ: begin
          if (mem_valid_in) begin
            fetch_pc_next = fetch_pc + XLEN'(PC_STEP);
            state_next    = (!halt_in && room) ? REQ : IDLE;
          end
        end
        DROP: if (mem_valid_in) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= IDLE;
      fetch_pc  <= RESET_ADDR;
      drop_addr <= RESET_ADDR;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      // fetch_pc is overwritten by a redirect, so the in-flight address
      // is kept separately for the DROP handshake.
      if (redirect_in && state == REQ) drop_addr <= fetch_pc;
    end
  end

  assign mem_read_out    = (state != IDLE);
  assign mem_addr_out    = (state == DROP) ? drop_addr : fetch_pc;
  assign ins_valid_out   = !empty;
  assign ins_data_out    = empty ? NOP : head[31:0];
  assign ins_pc_out      = empty ? '0 : head[W-1:32];
  assign queue_count_out = count;

  a_no_push_full: assert property (@(posedge clock_in) disable iff (reset_in)
    !(push && full));

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_in = 1'b1, halt = 1'b0, redirect = 1'b0, valid = 1'b0, ready = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] mem_addr, mem_data, ins_data, ins_pc;
  logic        mem_read, ins_valid;
  logic [2:0]  qcount;

  logic        reset_w = 1'b1;
  logic [31:0] mem_addr_w, mem_data_w, ins_data_w, ins_pc_w;
  logic        mem_read_w, ins_valid_w;
  logic [2:0]  qcount_w;

  // Memory responders: instruction word is address ^ KEY.
  assign mem_data   = mem_addr ^ KEY;
  assign mem_data_w = mem_addr_w ^ KEY;

  ifu_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .clock_in(clk), .reset_in(reset_in), .halt_in(halt), .redirect_in(redirect),
    .redirect_addr_in(raddr), .mem_addr_out(mem_addr), .mem_read_out(mem_read),
    .mem_valid_in(valid), .mem_data_in(mem_data), .ins_valid_out(ins_valid),
    .ins_data_out(ins_data), .ins_pc_out(ins_pc), .ins_ready_in(ready),
    .queue_count_out(qcount));

  ifu_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_ADDR(32'hFFFF_FFF8)) dut_w (
    .clock_in(clk), .reset_in(reset_w), .halt_in(1'b0), .redirect_in(1'b0),
    .redirect_addr_in(32'h0), .mem_addr_out(mem_addr_w), .mem_read_out(mem_read_w),
    .mem_valid_in(1'b1), .mem_data_in(mem_data_w), .ins_valid_out(ins_valid_w),
    .ins_data_out(ins_data_w), .ins_pc_out(ins_pc_w), .ins_ready_in(1'b1),
    .queue_count_out(qcount_w));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched words plus the state of the single
  // outstanding memory transaction.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        m_q[$];
  bit          m_init = 0, m_busy = 0, m_stale = 0;
  logic [31:0] m_pc = '0, m_req = '0;

  task automatic model_step();
    bit accept, take, may_issue;
    if (reset_in) begin
      m_q.delete(); m_pc = 32'h0; m_req = 32'h0;
      m_busy = 0; m_stale = 0; m_init = 1;
      return;
    end
    if (!m_init) return;
    accept = m_busy && valid;
    take   = ready && (m_q.size() > 0);
    if (redirect) begin
      m_q.delete();
      m_pc = {raddr[31:2], 2'b00};
      if (m_busy && !accept) m_stale = 1;   // stale response still owed
      else begin m_busy = 0; m_stale = 0; end
      return;
    end
    may_issue = !m_busy;
    if (take) void'(m_q.pop_front());
    if (accept) begin
      if (m_stale) begin
        m_stale = 0;
      end else begin
        m_q.push_back('{pc: m_req, ins: m_req ^ KEY});
        m_pc = m_pc + 32'd4;
        may_issue = 1;
      end
      m_busy = 0;
    end
    if (may_issue && !halt && m_q.size() < DEPTH) begin
      m_busy = 1;
      m_req  = m_pc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, outputs of the main DUT against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("mem_read", 32'(mem_read), 32'(m_busy));
      if (m_busy) check("mem_addr", mem_addr, m_req);
      check("ins_valid", 32'(ins_valid), 32'(m_q.size() > 0));
      check("ins_data", ins_data, (m_q.size() > 0) ? m_q[0].ins : NOP);
      check("ins_pc", ins_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
      check("queue_count", 32'(qcount), 32'(m_q.size()));
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rst mem_read"}, 32'(mem_read), 32'h0);
    check({tag, " rst mem_addr"}, mem_addr, 32'h0);
    check({tag, " rst ins_valid"}, 32'(ins_valid), 32'h0);
    check({tag, " rst ins_data"}, ins_data, NOP);
    check({tag, " rst ins_pc"}, ins_pc, 32'h0);
    check({tag, " rst count"}, 32'(qcount), 32'h0);
  endtask

  initial begin
    // Zero-wait memory, decode stalled: fill to DEPTH, then pop.
    valid = 1; ready = 0; reset_in = 1;
    nx(); check_reset_state("p1");
    reset_in = 0;
    nx();
    check("p1 first read", 32'(mem_read), 32'h1);
    check("p1 addr0", mem_addr, 32'h0);
    check("p1 head before valid", 32'(ins_valid), 32'h0);
    nx();
    check("p1 addr4", mem_addr, 32'h4);
    check("p1 head valid", 32'(ins_valid), 32'h1);
    check("p1 head pc", ins_pc, 32'h0);
    check("p1 head data", ins_data, 32'hA5A5_0000);
    nx(); check("p1 addr8", mem_addr, 32'h8);
    nx(); check("p1 addrC", mem_addr, 32'hC);
    nx();
    check("p1 full count", 32'(qcount), 32'h4);
    check("p1 full read", 32'(mem_read), 32'h0);
    ready = 1;
    nx();
    check("p1 pop reissue", 32'(mem_read), 32'h1);
    check("p1 addr10", mem_addr, 32'h10);
    nx();
    check("p1 pop+valid addr14", mem_addr, 32'h14);
    check("p1 pop+valid count", 32'(qcount), 32'h3);
    ready = 0;
    nx();
    check("p1 refull count", 32'(qcount), 32'h4);
    check("p1 refull head pc", ins_pc, 32'h8);

    // Redirect to 0x103 while the request to 0x8 waits.
    reset_in = 1; valid = 1; ready = 0;
    nx(); reset_in = 0;
    nx(); nx(); nx();
    check("p3 addr8", mem_addr, 32'h8);
    valid = 0;
    nx(); nx();
    redirect = 1; raddr = 32'h103;
    nx();
    check("p3 drop read", 32'(mem_read), 32'h1);
    check("p3 drop addr", mem_addr, 32'h8);
    check("p3 flushed", 32'(ins_valid), 32'h0);
    redirect = 0; valid = 1;
    nx(); check("p3 idle after drop", 32'(mem_read), 32'h0);
    nx(); check("p3 restart addr", mem_addr, 32'h100);
    nx();
    check("p3 head pc", ins_pc, 32'h100);
    check("p3 head data", ins_data, 32'hA5A5_0100);

    // Halt during an outstanding request.
    reset_in = 1; valid = 0; ready = 0;
    nx(); reset_in = 0;
    nx(); halt = 1;
    nx(); check("p4 held read", 32'(mem_read), 32'h1);
    valid = 1;
    nx();
    check("p4 halted read", 32'(mem_read), 32'h0);
    check("p4 queued", 32'(qcount), 32'h1);
    nx(); ready = 1;
    nx();
    check("p4 drained", 32'(qcount), 32'h0);
    check("p4 still halted", 32'(mem_read), 32'h0);
    halt = 0;
    nx(); check("p4 resume addr", mem_addr, 32'h4);

    // Wrapping PC from RESET_ADDR = FFFF_FFF8.
    check("pw rst addr", mem_addr_w, 32'hFFFF_FFF8);
    check("pw rst read", 32'(mem_read_w), 32'h0);
    reset_w = 0;
    nx(); check("pw addr F8", mem_addr_w, 32'hFFFF_FFF8);
    nx();
    check("pw addr FC", mem_addr_w, 32'hFFFF_FFFC);
    check("pw head pc", ins_pc_w, 32'hFFFF_FFF8);
    check("pw head data", ins_data_w, 32'h5A5A_FFF8);
    nx();
    check("pw addr wrap", mem_addr_w, 32'h0000_0000);
    check("pw head pc2", ins_pc_w, 32'hFFFF_FFFC);

    // Reset while busy with a loaded queue, then reset while in DROP.
    reset_in = 1; valid = 1; ready = 0; halt = 0;
    nx(); reset_in = 0;
    nx(); nx(); nx(); nx();
    check("p6 loaded count", 32'(qcount), 32'h3);
    valid = 0; reset_in = 1;
    nx(); check_reset_state("p6a");
    reset_in = 0;
    nx(); redirect = 1; raddr = 32'h40;
    nx();
    check("p6 drop addr", mem_addr, 32'h0);
    redirect = 0; reset_in = 1;
    nx(); check_reset_state("p6b");
    reset_in = 0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int unsigned mode;
      mode     = (i / 500) % 4;
      reset_in = ($urandom_range(0, 199) == 0);
      halt     = ($urandom_range(0, 9) < (mode == 2 ? 5 : 1));
      redirect = ($urandom_range(0, 19) == 0);
      raddr    = $urandom;
      valid    = ($urandom_range(0, 3) < (mode == 1 ? 4 : 2));
      ready    = ($urandom_range(0, 3) < (mode == 3 ? 1 : 3));
      nx();
    end
    reset_in = 0; halt = 0; redirect = 0; valid = 0; ready = 0;
    nx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
